// File: rtl/tone_pkg.sv
// tone_pkg: note constants, top-octave pitch table, half-period helper and command FSM states
package tone_pkg;
  localparam int NOTE_REST = 0;
  localparam int NOTE_HOLD = 8'hFF;
  localparam int NOTE_MAX = 84;
  localparam int TOP_OCT = 6;
  localparam int SEMIS = 12;
  // C7..B7 in milli-Hz
  localparam longint TOP_MHZ [SEMIS] = '{
    64'd2093005, 64'd2217461, 64'd2349318, 64'd2489016, 64'd2637020, 64'd2793826,
    64'd2959955, 64'd3135963, 64'd3322438, 64'd3520000, 64'd3729310, 64'd3951066
  };
  function automatic longint half_period(longint clkHz, int semitone);
    return (clkHz * 1000 + TOP_MHZ[semitone]) / (2 * TOP_MHZ[semitone]);
  endfunction
  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;
endpackage

// File: rtl/tone_channel.sv
// tone_channel: one square-wave voice with a half-period counter and load/silence strobes
module tone_channel #(
  parameter int PER_W = 16
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iLoad,
  input  logic             iSilence,
  input  logic [PER_W-1:0] iHalf,
  output logic             oWave,
  output logic             oActive
);
  logic [PER_W-1:0] half;
  logic [PER_W-1:0] count;
  logic wave;
  // a load keeps the current level so a retune never glitches the output
  always_ff @(posedge iClk) begin
    if (iReset || iSilence) begin
      half <= '0;
      count <= '0;
      wave <= 1'b0;
    end else if (iLoad) begin
      half <= iHalf;
      count <= '0;
    end else if (half == '0) begin
      count <= '0;
      wave <= 1'b0;
    end else if (count == half - 1'b1) begin
      count <= '0;
      wave <= ~wave;
    end else begin
      count <= count + 1'b1;
    end
  end
  assign oWave = wave;
  assign oActive = half != '0;
endmodule

// File: rtl/tone_channel_bank.sv
// tone_channel_bank: note-command front end with octave divider driving a bank of tone channels
module tone_channel_bank
  import tone_pkg::*;
#(
  parameter int CLK_HZ = 1_000_000,
  parameter int CHANNELS = 4,
  parameter int NOTE_W = 8,
  parameter int PER_W = 16,
  localparam int CHAN_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iCmdValid,
  input  logic [CHAN_W-1:0]   iCmdChan,
  input  logic [NOTE_W-1:0]   iCmdNote,
  output logic                oCmdReady,
  output logic                oCmdErr,
  output logic [CHANNELS-1:0] oWave,
  output logic                oMix,
  output logic [CHANNELS-1:0] oActive
);
  if (CHANNELS < 1 || CHANNELS > 16 || longint'(CLK_HZ) * 64 / 4186 >= (longint'(1) << PER_W)) begin : gParamCheck
    $error("tone_channel_bank: unsupported CHANNELS or PER_W too narrow for CLK_HZ");
  end
  state_t state, nextState;
  logic [NOTE_W-1:0] rem;
  logic [2:0] oct;
  logic [CHAN_W-1:0] chan;
  logic err, accept, isRest, isHold, isBad, start, loadNow;
  logic [PER_W-1:0] baseTab [SEMIS];
  logic [PER_W-1:0] loadHalf;
  logic [CHANNELS-1:0] loadVec, silenceVec;
  for (genvar i = 0; i < SEMIS; i++) begin : gBase
    localparam logic [PER_W-1:0] B = PER_W'(half_period(CLK_HZ, i));
    assign baseTab[i] = B;
  end
  always_comb begin
    accept = iCmdValid && state == IDLE;
    isRest = iCmdNote == NOTE_W'(NOTE_REST);
    isHold = iCmdNote == NOTE_W'(NOTE_HOLD);
    isBad = 32'(iCmdChan) >= CHANNELS || (32'(iCmdNote) > NOTE_MAX && !isHold);
    start = accept && !isBad && !isRest && !isHold;
  end
  always_ff @(posedge iClk) state <= iReset ? IDLE : nextState;
  always_comb begin
    nextState = state == IDLE ? (start ? DIV : IDLE)
              : state == DIV ? (rem < NOTE_W'(SEMIS) ? LOAD : DIV)
              : IDLE;
  end
  always_comb begin
    oCmdReady = state == IDLE;
    loadNow = state == LOAD;
    loadHalf = baseTab[rem[3:0]] << (3'(TOP_OCT) - oct);
    for (int k = 0; k < CHANNELS; k++) begin
      loadVec[k] = loadNow && chan == CHAN_W'(k);
      silenceVec[k] = accept && isRest && !isBad && iCmdChan == CHAN_W'(k);
    end
  end
  // repeated subtraction of 12 turns the note index into (octave, semitone)
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rem <= '0;
      oct <= '0;
      chan <= '0;
      err <= 1'b0;
    end else begin
      err <= accept && isBad;
      if (start) begin
        chan <= iCmdChan;
        rem <= iCmdNote - 1'b1;
        oct <= '0;
      end else if (state == DIV && rem >= NOTE_W'(SEMIS)) begin
        rem <= rem - NOTE_W'(SEMIS);
        oct <= oct + 1'b1;
      end
    end
  end
  assign oCmdErr = err;
  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    tone_channel #(.PER_W(PER_W)) uChan (
      .iClk     (iClk),
      .iReset   (iReset),
      .iLoad    (loadVec[c]),
      .iSilence (silenceVec[c]),
      .iHalf    (loadHalf),
      .oWave    (oWave[c]),
      .oActive  (oActive[c])
    );
  end
  assign oMix = |oWave;
endmodule

// File: tb/tb_tone_channel_bank.sv
// tb_tone_channel_bank: randomized note commands scored against a pitch/period reference model
module tb_tone_channel_bank;
  localparam int CHANNELS = 3;
  localparam int CH_W = 2;
  localparam int NOTE_W = 8;
  localparam int PER_W = 16;
  localparam int CLK_HZ = 1_000_000;
  logic iClk = 1'b0;
  logic iReset = 1'b1;
  logic iCmdValid = 1'b0;
  logic [CH_W-1:0] iCmdChan = '0;
  logic [NOTE_W-1:0] iCmdNote = '0;
  logic oCmdReady, oCmdErr, oMix;
  logic [CHANNELS-1:0] oWave, oActive;

  tone_channel_bank #(.CLK_HZ(CLK_HZ), .CHANNELS(CHANNELS), .NOTE_W(NOTE_W), .PER_W(PER_W)) dut (
    .iClk      (iClk),
    .iReset    (iReset),
    .iCmdValid (iCmdValid),
    .iCmdChan  (iCmdChan),
    .iCmdNote  (iCmdNote),
    .oCmdReady (oCmdReady),
    .oCmdErr   (oCmdErr),
    .oWave     (oWave),
    .oMix      (oMix),
    .oActive   (oActive)
  );

  always #5 iClk = ~iClk;

  typedef struct { int cyc; int chan; int half; } ev_t;
  typedef struct { bit isErr; int cyc; } resp_t;
  ev_t evQ[$];
  resp_t respQ[$];
  ev_t ev;
  resp_t rsp;
  int cyc = 0;
  logic rstEdge = 1'b1;
  int checks = 0;
  int errors = 0;
  int mHalf [CHANNELS];
  int mLoad [CHANNELS];
  logic [CHANNELS-1:0] mWave = '0;
  logic [CHANNELS-1:0] expAct;
  logic [CHANNELS-1:0] touched;
  int busyA = 0;
  int busyD = 0;
  bit monOn = 0;
  logic readyPrev = 1'b1;
  int d0;

  always @(posedge iClk) begin
    cyc <= cyc + 1;
    rstEdge <= iReset;
  end

  // equal-tempered pitch anchored at A7 = 3520 Hz, rounded top-octave half period scaled by octave
  function automatic int refHalf(int note);
    int s = (note - 1) % 12;
    int oct = (note - 1) / 12;
    real f = 3520.0 * (2.0 ** ((s - 9) / 12.0));
    return $rtoi($floor(CLK_HZ / (2.0 * f) + 0.5)) * (1 << (6 - oct));
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic pushEv(int c, int ch, int h);
    ev_t e;
    e.cyc = c;
    e.chan = ch;
    e.half = h;
    evQ.push_back(e);
  endtask

  task automatic pushResp(bit isErr, int c);
    resp_t r;
    r.isErr = isErr;
    r.cyc = c;
    respQ.push_back(r);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic send(int ch, int note);
    int t = 0;
    int a;
    int d;
    while (!oCmdReady && t < 3000) begin
      @(negedge iClk);
      t++;
    end
    if (!oCmdReady) check("ready_wait", 0, 1);
    a = cyc + 1;
    iCmdValid = 1'b1;
    iCmdChan = CH_W'(ch);
    iCmdNote = NOTE_W'(note);
    if (ch >= CHANNELS || (note > 84 && note != 255)) pushResp(1'b1, a);
    else if (note == 0) pushEv(a, ch, 0);
    else if (note != 255) begin
      d = a + (note - 1) / 12 + 2;
      pushEv(d, ch, refHalf(note));
      pushResp(1'b0, d);
      busyA = a;
      busyD = d;
    end
    @(negedge iClk);
    iCmdValid = 1'b0;
  endtask

  initial forever begin
    @(negedge iClk);
    if (monOn) begin
      touched = '0;
      while (evQ.size() > 0 && evQ[0].cyc == cyc) begin
        ev = evQ.pop_front();
        for (int c = 0; c < CHANNELS; c++)
          if (ev.chan < 0 || ev.chan == c) begin
            touched[c] = 1'b1;
            mHalf[c] = ev.half;
            mLoad[c] = cyc;
            if (ev.half == 0) mWave[c] = 1'b0;
          end
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (!touched[c] && mHalf[c] != 0 && (cyc - mLoad[c]) % mHalf[c] == 0) mWave[c] = ~mWave[c];
        expAct[c] = mHalf[c] != 0;
      end
      check("wave", int'(oWave), int'(mWave));
      check("active", int'(oActive), int'(expAct));
      check("mix", int'(oMix), int'(|mWave));
      check("ready", int'(oCmdReady), int'(!(cyc >= busyA && cyc < busyD)));
      if (oCmdErr || (oCmdReady && !readyPrev && !rstEdge)) begin
        if (respQ.size() == 0) check(oCmdErr ? "unexpected_err" : "unexpected_ready", 1, 0);
        else begin
          rsp = respQ.pop_front();
          check("resp_kind", int'(oCmdErr), int'(rsp.isErr));
          check(rsp.isErr ? "err_cycle" : "load_cycle", cyc, rsp.cyc);
        end
      end
      if (respQ.size() > 0 && respQ[0].cyc < cyc) begin
        check("resp_timeout", cyc, respQ[0].cyc);
        rsp = respQ.pop_front();
      end
      readyPrev = oCmdReady;
    end
  end

  initial begin
    int k;
    int tgt;
    int r;
    int ch;
    int note;
    for (int c = 0; c < CHANNELS; c++) begin
      mHalf[c] = 0;
      mLoad[c] = 0;
    end
    idle(3);
    iReset = 1'b0;
    monOn = 1;
    idle(2);
    send(0, 46);
    d0 = busyD;
    idle(2400);
    send(1, 1);
    send(2, 84);
    idle(400);
    k = (cyc + 20 - d0) / 1136 + 1;
    tgt = d0 + 1136 * k;
    while (cyc != tgt - 9) @(negedge iClk);
    send(0, 82);
    idle(700);
    send(0, 0);
    idle(3);
    send(0, 255);
    idle(3);
    send(0, 85);
    idle(2);
    send(3, 46);
    idle(2);
    send(1, 200);
    idle(3);
    send(1, 80);
    iReset = 1'b1;
    evQ.delete();
    respQ.delete();
    pushEv(cyc + 1, -1, 0);
    busyD = cyc + 1;
    idle(2);
    iReset = 1'b0;
    idle(3);
    check("ready_after_reset", int'(oCmdReady), 1);
    check("active_after_reset", int'(oActive), 0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      ch = $urandom_range(0, CHANNELS - 1);
      note = $urandom_range(1, 84);
      if (r == 0) note = 0;
      else if (r == 1) note = 255;
      else if (r == 2) note = $urandom_range(85, 254);
      else if (r == 3) ch = 3;
      send(ch, note);
      idle($urandom_range(0, 400));
    end
    idle(20);
    check("resp_queue_empty", respQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
